// File: rtl/cars_pkg.sv
// Shared types and constants for the 2Cars obstacle path.
// Lanes 0/1 belong to the left car, lanes 2/3 to the right car.
package cars_pkg;

    localparam logic [1:0] LANE_L0 = 2'd0;
    localparam logic [1:0] LANE_L1 = 2'd1;
    localparam logic [1:0] LANE_R0 = 2'd2;
    localparam logic [1:0] LANE_R1 = 2'd3;

    localparam logic KIND_CIRCLE = 1'b0;
    localparam logic KIND_SQUARE = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StPushL,
        StPushR
    } spawn_state_t;

    typedef struct packed {
        logic [1:0] lane;
        logic       kind;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/spawn_fifo.sv
// Synchronous FIFO for obstacle entries. A push into a full FIFO succeeds only
// when a pop happens on the same edge; read data is forced to zero while empty.
module spawn_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 3,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AddrW:0]   count
);

    localparam logic [AddrW:0] FullCount = (AddrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q;
    logic [AddrW-1:0] rptr_q;
    logic [AddrW:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCount);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rstn && do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/obstacle_spawner.sv
// Every SPAWN_PERIOD enabled frame ticks, decodes the LFSR word into one or two
// obstacle entries and queues them for the track logic.
module obstacle_spawner
    import cars_pkg::*;
#(
    parameter int unsigned SPAWN_PERIOD = 50,
    parameter int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned CountW      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tick,
    input  logic              enable,
    input  logic [4:0]        rnd,
    output logic              spawn_valid,
    output logic [1:0]        spawn_lane,
    output logic              spawn_kind,
    input  logic              spawn_ready,
    output logic [CountW-1:0] fifo_count,
    output logic              overflow
);

    localparam int unsigned CntW = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SPAWN_PERIOD - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            spawn_event;
    spawn_state_t    state_q, state_d;
    logic [4:0]      rnd_q, rnd_d;
    logic            toggle_q, toggle_d;
    logic            overflow_q, overflow_d;
    logic            push;
    entry_t          wentry;
    entry_t          rentry;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;

    always_comb begin
        cnt_d       = cnt_q;
        spawn_event = 1'b0;
        if (tick && enable) begin
            if (cnt_q == CntLast) begin
                cnt_d       = '0;
                spawn_event = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rnd_d    = rnd_q;
        toggle_d = toggle_q;
        push     = 1'b0;
        wentry   = '0;
        case (state_q)
            StIdle: begin
                if (spawn_event) begin
                    rnd_d = rnd;
                    if (rnd[4]) begin
                        state_d = StPushL;
                    end else begin
                        // Single-side events alternate sides, starting left.
                        state_d  = toggle_q ? StPushR : StPushL;
                        toggle_d = ~toggle_q;
                    end
                end
            end
            StPushL: begin
                push        = 1'b1;
                wentry.lane = rnd_q[0] ? LANE_L1 : LANE_L0;
                wentry.kind = rnd_q[1] ? KIND_SQUARE : KIND_CIRCLE;
                state_d     = rnd_q[4] ? StPushR : StIdle;
            end
            StPushR: begin
                push        = 1'b1;
                wentry.lane = rnd_q[2] ? LANE_R1 : LANE_R0;
                wentry.kind = rnd_q[3] ? KIND_SQUARE : KIND_CIRCLE;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign pop = !fifo_empty && spawn_ready;

    always_comb begin
        overflow_d = overflow_q;
        if (spawn_event && (state_q != StIdle)) begin
            overflow_d = 1'b1;
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q      <= '0;
            state_q    <= StIdle;
            rnd_q      <= '0;
            toggle_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            toggle_q   <= toggle_d;
            overflow_q <= overflow_d;
        end
    end

    spawn_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (rentry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign spawn_valid = !fifo_empty;
    assign spawn_lane  = rentry.lane;
    assign spawn_kind  = rentry.kind;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed and randomized checks of obstacle_spawner against a queue-based
// model of the spawn rules.
module tb_obstacle_spawner;

    localparam int unsigned P = 4;
    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tick;
    logic       enable;
    logic [4:0] rnd;
    logic       spawn_ready;
    logic       spawn_valid;
    logic [1:0] spawn_lane;
    logic       spawn_kind;
    logic [2:0] fifo_count;
    logic       overflow;

    always #5 clk = ~clk;

    obstacle_spawner #(
        .SPAWN_PERIOD (P),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .tick        (tick),
        .enable      (enable),
        .rnd         (rnd),
        .spawn_valid (spawn_valid),
        .spawn_lane  (spawn_lane),
        .spawn_kind  (spawn_kind),
        .spawn_ready (spawn_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    int checks = 0;
    int errors = 0;

    // Model: tick count, side toggle, sticky overflow, queued entries, and the
    // entries of the current event still waiting for their one-per-cycle write.
    int         m_cnt;
    bit         m_toggle;
    bit         m_ovf;
    logic [2:0] m_fifo[$];
    logic [2:0] m_pend[$];

    function automatic logic [2:0] left_entry(input logic [4:0] r);
        logic [1:0] lane;
        lane = r[0] ? 2'd1 : 2'd0;
        return {lane, r[1]};
    endfunction

    function automatic logic [2:0] right_entry(input logic [4:0] r);
        logic [1:0] lane;
        lane = 2'(2 + int'(r[2]));
        return {lane, r[3]};
    endfunction

    task automatic model_step();
        bit         busy;
        bit         pop;
        bit         ev;
        logic [2:0] e;
        if (!rstn) begin
            m_cnt    = 0;
            m_toggle = 0;
            m_ovf    = 0;
            m_fifo.delete();
            m_pend.delete();
            return;
        end
        busy = (m_pend.size() > 0);
        pop  = (m_fifo.size() > 0) && spawn_ready;
        if (pop) void'(m_fifo.pop_front());
        if (busy) begin
            e = m_pend.pop_front();
            if (m_fifo.size() >= D) m_ovf = 1;
            else m_fifo.push_back(e);
        end
        ev = 0;
        if (tick && enable) begin
            if (m_cnt == P - 1) begin
                m_cnt = 0;
                ev    = 1;
            end else begin
                m_cnt++;
            end
        end
        if (ev) begin
            if (busy) begin
                m_ovf = 1;
            end else if (rnd[4]) begin
                m_pend.push_back(left_entry(rnd));
                m_pend.push_back(right_entry(rnd));
            end else if (!m_toggle) begin
                m_pend.push_back(left_entry(rnd));
                m_toggle = 1;
            end else begin
                m_pend.push_back(right_entry(rnd));
                m_toggle = 0;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [2:0] head;
        logic       exp_valid;
        logic [2:0] exp_count;
        head      = (m_fifo.size() > 0) ? m_fifo[0] : 3'b000;
        exp_valid = (m_fifo.size() > 0);
        exp_count = 3'(m_fifo.size());
        checks++;
        assert (spawn_valid === exp_valid) else begin
            errors++;
            $error("FAIL %s valid: got %b expected %b", tag, spawn_valid, exp_valid);
        end
        checks++;
        assert (spawn_lane === head[2:1]) else begin
            errors++;
            $error("FAIL %s lane: got %0d expected %0d", tag, spawn_lane, head[2:1]);
        end
        checks++;
        assert (spawn_kind === head[0]) else begin
            errors++;
            $error("FAIL %s kind: got %b expected %b", tag, spawn_kind, head[0]);
        end
        checks++;
        assert (fifo_count === exp_count) else begin
            errors++;
            $error("FAIL %s count: got %0d expected %0d", tag, fifo_count, exp_count);
        end
        checks++;
        assert (overflow === m_ovf) else begin
            errors++;
            $error("FAIL %s overflow: got %b expected %b", tag, overflow, m_ovf);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag);
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) cycle(tag);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cycle("reset");
        rstn = 1'b1;
    endtask

    initial begin
        bit found;
        rstn        = 1'b0;
        tick        = 1'b0;
        enable      = 1'b0;
        rnd         = 5'd0;
        spawn_ready = 1'b0;
        run(2, "reset");
        rstn = 1'b1;
        run(2, "idle");

        // Both sides from a fixed word.
        do_reset();
        tick   = 1'b1;
        enable = 1'b1;
        rnd    = 5'b10101;
        run(9, "both");

        // Single-side alternation.
        do_reset();
        rnd = 5'b00011;
        run(10, "toggle");

        // Five both-sides events into a stalled FIFO, then drain.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            rnd = 5'($urandom) | 5'h10;
            cycle("fill");
        end
        spawn_ready = 1'b1;
        run(8, "drain");
        spawn_ready = 1'b0;

        // Full FIFO with a pop on the same edge as the PUSH_L write.
        do_reset();
        rnd = 5'h1f;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle("fullpop_wait");
            if (m_fifo.size() == D && m_pend.size() == 2) found = 1;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL fullpop_wait: got timeout expected full FIFO with pending pair");
        end
        spawn_ready = 1'b1;
        run(2, "fullpop");
        spawn_ready = 1'b0;
        run(3, "fullpop_after");

        // Enable gating mid-period.
        do_reset();
        rnd = 5'b00110;
        run(2, "en_pre");
        enable = 1'b0;
        run(10, "en_off");
        enable = 1'b1;
        run(6, "en_on");

        // Reset during PUSH_L with two entries queued.
        do_reset();
        rnd = 5'h1e;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle("rst_wait");
            if (m_fifo.size() == 2 && m_pend.size() == 2) found = 1;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL rst_wait: got timeout expected pending pair with 2 queued");
        end
        rstn = 1'b0;
        cycle("rst_mid");
        rstn = 1'b1;
        tick = 1'b0;
        run(4, "rst_after");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            tick        = ($urandom_range(0, 3) != 0);
            enable      = ($urandom_range(0, 9) != 0);
            spawn_ready = ($urandom_range(0, 2) == 0);
            rnd         = 5'($urandom);
            rstn        = ($urandom_range(0, 99) != 0);
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
